csip_commit_sync: RTL and testbench
===================================

# csip_commit_sync

Parametrised successor to the CS:IP update synchroniser. It collects segment and offset updates written by microcode during a microinstruction and merges them with the architectural values. It commits the pair atomically as a single registered transfer to the prefetcher over a valid/ready handshake. One commit slot decouples microcode from a prefetcher that stalls, and a first-wins or last-wins merge mode is selectable per instance.

## Interface
Parameters:
- SEG_W, 16, segment register width
- OFS_W, 16, offset (IP) width
- LAST_WINS, 0, 0: first offset/segment write in a microinstruction is kept; 1: last write is kept

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- seg_update  in  1  microcode writes segment this cycle
- seg_in  in  SEG_W  new segment value
- ofs_update  in  1  microcode writes offset this cycle
- ofs_in  in  OFS_W  new offset value
- cur_seg  in  SEG_W  architectural segment, used when segment not written
- cur_ofs  in  OFS_W  architectural offset, used when offset not written
- propagate  in  1  end of microinstruction; commit if anything pending
- abort  in  1  discard all pending (uncommitted) updates
- commit_stall  out  1  propagate cannot be accepted this cycle
- fetch_valid  out  1  commit slot holds a CS:IP pair
- fetch_ready  in  1  prefetcher accepts the pair
- fetch_seg  out  SEG_W  committed segment
- fetch_ofs  out  OFS_W  committed offset

## Operation
- Accumulator: seg_pend/ofs_pend flags plus seg_acc/ofs_acc registers.
- On seg_update: if !seg_pend or LAST_WINS, seg_acc <= seg_in. seg_pend <= 1. Offset behaves identically.
- Merge value at propagate (the same-cycle update is included):
  - seg = seg_pend&&!(LAST_WINS&&seg_update) ? seg_acc : seg_update ? seg_in : cur_seg.
  - ofs follows the same rule.
- any_pend = seg_pend | ofs_pend | seg_update | ofs_update.
- Commit slot FSM, two states:
  - EMPTY: fetch_valid=0.
  - FULL: fetch_valid=1. fetch_seg/fetch_ofs are stable until the handshake completes.
- Load condition: propagate && any_pend && !abort && !commit_stall. Effect: the slot takes the merge values and the state becomes FULL. The accumulator clears, and same-cycle updates are consumed, not re-accumulated.
- commit_stall = FULL && !fetch_ready && propagate && any_pend. Microcode holds propagate high and all update inputs stable while the stall is asserted.
- FULL with fetch_valid && fetch_ready: the next state is EMPTY, unless a load happens in the same cycle, in which case it stays FULL with the new pair. Back-to-back commits are supported at full rate.
- propagate with !any_pend: no load, the accumulator is unchanged, and commit_stall=0.
- abort: clears seg_pend/ofs_pend and ignores same-cycle updates. abort wins over propagate. It never withdraws a FULL slot, because valid does not drop before ready.
- Reset (async, reset_n=0): state EMPTY, fetch_valid=0, commit_stall=0, pend flags 0, fetch_seg/fetch_ofs=0, accumulators=0.

## Timing
- Latency from propagate to fetch_valid: 1 cycle, registered. fetch_seg/fetch_ofs are valid in the same cycle as fetch_valid.
- commit_stall is combinational from propagate, the update inputs and fetch_ready. It must not feed back into propagate within the same cycle.
- Update then propagate in later cycles: the accumulated values are used. An update and propagate in the same cycle are both honoured.
- Reset released mid-transfer: the slot is empty, so the prefetcher sees no stale pair.
- Throughput: one commit per cycle when fetch_ready is held high.

## Structure
- Shared package csip_pkg: typedef csip_pair_t (packed seg, ofs). This package is parametrised through SEG_W/OFS_W defaults of 16, with enum slot_state_t {SLOT_EMPTY, SLOT_FULL}.
- A single sub-module is natural: csip_accum, one instance per field (segment, offset). It holds the flag, the value and the first/last-wins merge logic. The top level holds the slot FSM and the handshake.

## Test plan
- ofs_update ofs_in=0x1234 at cycle 0, seg_update seg_in=0xF000 at cycle 2, propagate at cycle 3 -> cycle 4 fetch_valid=1, fetch_seg=0xF000, fetch_ofs=0x1234; single beat with fetch_ready=1.
- LAST_WINS=0: ofs_in 0x0010 then 0x0020, then propagate with cur_seg=0x0700 -> fetch_ofs=0x0010, fetch_seg=0x0700. With LAST_WINS=1 -> fetch_ofs=0x0020.
- fetch_ready=0 with the slot FULL, then propagate with ofs_update 0x0100 -> commit_stall=1 and the slot is unchanged. Raise fetch_ready -> the first pair is accepted and 0x0100 loads in the same cycle with no bubble.
- seg_update 0x1000, then abort together with propagate -> no fetch_valid; a subsequent propagate with no updates -> still no fetch_valid.
- propagate with no updates and no pending flags -> fetch_valid stays 0 and commit_stall=0.
- reset_n low while FULL with fetch_ready=0 -> fetch_valid=0 immediately (async). After release, all outputs are 0 and the pend flags are clear.

Source files
------------

// File: rtl/csip_pkg.sv
// Shared types for the CS:IP commit synchroniser: committed pair layout and
// the two-state commit slot encoding.
package csip_pkg;

  localparam int SEG_W = 16;
  localparam int OFS_W = 16;

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [OFS_W-1:0] ofs;
  } csip_pair_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/csip_commit_sync_if.sv
// Valid/ready transfer of a committed CS:IP pair to the prefetcher.
interface csip_commit_sync_if #(
  parameter int SEG_W = 16,
  parameter int OFS_W = 16
);

  logic             fetch_valid;
  logic             fetch_ready;
  logic [SEG_W-1:0] fetch_seg;
  logic [OFS_W-1:0] fetch_ofs;

  modport master (
    output fetch_valid,
    output fetch_seg,
    output fetch_ofs,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_seg,
    input  fetch_ofs,
    output fetch_ready
  );

endinterface

// File: rtl/csip_accum.sv
// Per-field update accumulator: pending flag, held value and first/last-wins
// merge against the architectural value.
module csip_accum #(
  parameter int W         = 16,
  parameter bit LAST_WINS = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         update,
  input  logic [W-1:0] din,
  input  logic [W-1:0] cur,
  input  logic         clear,
  output logic         pend,
  output logic [W-1:0] merged
);

  logic [W-1:0] acc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      acc  <= '0;
    end else if (clear) begin
      // A commit consumes and an abort drops any same-cycle update.
      pend <= 1'b0;
      acc  <= '0;
    end else if (update) begin
      pend <= 1'b1;
      if (!pend || LAST_WINS) acc <= din;
    end
  end

  always_comb begin
    if (pend && !(LAST_WINS && update)) merged = acc;
    else if (update)                     merged = din;
    else                                 merged = cur;
  end

endmodule

// File: rtl/csip_commit_sync.sv
// Merges microcode CS:IP updates and commits the pair atomically through a
// one-entry slot to the prefetcher.
module csip_commit_sync #(
  parameter int SEG_W     = 16,
  parameter int OFS_W     = 16,
  parameter bit LAST_WINS = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seg_update,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             ofs_update,
  input  logic [OFS_W-1:0] ofs_in,
  input  logic [SEG_W-1:0] cur_seg,
  input  logic [OFS_W-1:0] cur_ofs,
  input  logic             propagate,
  input  logic             abort,
  output logic             commit_stall,
  csip_commit_sync_if.master fetch
);

  csip_pkg::slot_state_t state_q, state_d;

  logic             seg_pend, ofs_pend;
  logic [SEG_W-1:0] seg_merged, seg_q;
  logic [OFS_W-1:0] ofs_merged, ofs_q;
  logic             any_pend, load, acc_clear;

  assign any_pend     = seg_pend | ofs_pend | seg_update | ofs_update;
  assign commit_stall = (state_q == csip_pkg::SLOT_FULL) && !fetch.fetch_ready
                        && propagate && any_pend;
  assign load         = propagate && any_pend && !abort && !commit_stall;
  assign acc_clear    = load || abort;

  csip_accum #(.W(SEG_W), .LAST_WINS(LAST_WINS)) u_seg_accum (
    .clk    (clk),
    .reset_n(reset_n),
    .update (seg_update),
    .din    (seg_in),
    .cur    (cur_seg),
    .clear  (acc_clear),
    .pend   (seg_pend),
    .merged (seg_merged)
  );

  csip_accum #(.W(OFS_W), .LAST_WINS(LAST_WINS)) u_ofs_accum (
    .clk    (clk),
    .reset_n(reset_n),
    .update (ofs_update),
    .din    (ofs_in),
    .cur    (cur_ofs),
    .clear  (acc_clear),
    .pend   (ofs_pend),
    .merged (ofs_merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= csip_pkg::SLOT_EMPTY;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      csip_pkg::SLOT_EMPTY: if (load) state_d = csip_pkg::SLOT_FULL;
      csip_pkg::SLOT_FULL: begin
        // A load in the handshake cycle refills the slot with no bubble.
        if (load)                   state_d = csip_pkg::SLOT_FULL;
        else if (fetch.fetch_ready) state_d = csip_pkg::SLOT_EMPTY;
      end
      default: state_d = csip_pkg::SLOT_EMPTY;
    endcase
  end

  // NOTE: the pair register is reset even though fetch_valid qualifies it,
  // so the prefetcher never observes X or a stale pair after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      ofs_q <= '0;
    end else if (load) begin
      seg_q <= seg_merged;
      ofs_q <= ofs_merged;
    end
  end

  assign fetch.fetch_valid = (state_q == csip_pkg::SLOT_FULL);
  assign fetch.fetch_seg   = seg_q;
  assign fetch.fetch_ofs   = ofs_q;

endmodule

// File: tb/tb_csip_commit_sync.sv
// Self-checking bench: first-wins and last-wins instances share stimulus and
// are compared every cycle against a queue-based model of the commit rules.
module tb_csip_commit_sync;
  import csip_pkg::*;

  typedef logic [15:0] val_q_t[$];

  logic        clk = 1'b0;
  logic        reset_n;
  logic        seg_update, ofs_update, propagate, abort, fetch_ready;
  logic [15:0] seg_in, ofs_in, cur_seg, cur_ofs;
  logic        stall0, stall1;

  int n_total = 0;
  int n_pass  = 0;

  csip_commit_sync_if #(.SEG_W(16), .OFS_W(16)) if0 ();
  csip_commit_sync_if #(.SEG_W(16), .OFS_W(16)) if1 ();
  assign if0.fetch_ready = fetch_ready;
  assign if1.fetch_ready = fetch_ready;

  csip_commit_sync #(.SEG_W(16), .OFS_W(16), .LAST_WINS(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .seg_update(seg_update), .seg_in(seg_in),
    .ofs_update(ofs_update), .ofs_in(ofs_in), .cur_seg(cur_seg), .cur_ofs(cur_ofs),
    .propagate(propagate), .abort(abort), .commit_stall(stall0), .fetch(if0.master)
  );

  csip_commit_sync #(.SEG_W(16), .OFS_W(16), .LAST_WINS(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .seg_update(seg_update), .seg_in(seg_in),
    .ofs_update(ofs_update), .ofs_in(ofs_in), .cur_seg(cur_seg), .cur_ofs(cur_ofs),
    .propagate(propagate), .abort(abort), .commit_stall(stall1), .fetch(if1.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the writes seen in the current microinstruction, plus the slot.
  val_q_t     seg_q, ofs_q;
  bit         m_valid;
  bit         m_stall_prev;
  csip_pair_t m_pair [2];

  function automatic logic [15:0] pick(input val_q_t q, input logic upd,
                                       input logic [15:0] din, input logic [15:0] cur,
                                       input bit lw);
    if (q.size() == 0 && !upd) return cur;
    if (lw) return upd ? din : q[q.size()-1];
    return (q.size() > 0) ? q[0] : din;
  endfunction

  function automatic bit model_any();
    return (seg_q.size() > 0) || (ofs_q.size() > 0) || seg_update || ofs_update;
  endfunction

  function automatic bit model_stall();
    return m_valid && !fetch_ready && propagate && model_any();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q.delete();
      ofs_q.delete();
      m_valid      = 1'b0;
      m_stall_prev = 1'b0;
      m_pair[0]    = '0;
      m_pair[1]    = '0;
    end else begin
      bit st, ld;
      st = model_stall();
      ld = propagate && model_any() && !abort && !st;
      m_stall_prev = st;
      if (ld) begin
        for (int lw = 0; lw < 2; lw++) begin
          m_pair[lw].seg = pick(seg_q, seg_update, seg_in, cur_seg, lw[0]);
          m_pair[lw].ofs = pick(ofs_q, ofs_update, ofs_in, cur_ofs, lw[0]);
        end
        m_valid = 1'b1;
        seg_q.delete();
        ofs_q.delete();
      end else begin
        if (m_valid && fetch_ready) m_valid = 1'b0;
        if (abort) begin
          seg_q.delete();
          ofs_q.delete();
        end else begin
          if (seg_update) seg_q.push_back(seg_in);
          if (ofs_update) ofs_q.push_back(ofs_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("stall_lw0", 32'(stall0), 32'(model_stall()));
      check("stall_lw1", 32'(stall1), 32'(model_stall()));
      check("valid_lw0", 32'(if0.fetch_valid), 32'(m_valid));
      check("valid_lw1", 32'(if1.fetch_valid), 32'(m_valid));
      if (m_valid) begin
        check("seg_lw0", 32'(if0.fetch_seg), 32'(m_pair[0].seg));
        check("ofs_lw0", 32'(if0.fetch_ofs), 32'(m_pair[0].ofs));
        check("seg_lw1", 32'(if1.fetch_seg), 32'(m_pair[1].seg));
        check("ofs_lw1", 32'(if1.fetch_ofs), 32'(m_pair[1].ofs));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    seg_update = 1'b0;
    ofs_update = 1'b0;
    propagate  = 1'b0;
    abort      = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    set_idle();
    seg_in      = '0;
    ofs_in      = '0;
    cur_seg     = 16'h0700;
    cur_ofs     = 16'h5555;
    fetch_ready = 1'b1;
    repeat (2) step();
    check("rst_valid", 32'(if0.fetch_valid), 32'd0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_seg",   32'(if0.fetch_seg), 32'd0);
    check("rst_ofs",   32'(if1.fetch_ofs), 32'd0);
    reset_n = 1'b1;
    step();

    // Offset, gap, segment, then propagate: one registered commit.
    ofs_update = 1'b1; ofs_in = 16'h1234; step();
    set_idle(); step();
    seg_update = 1'b1; seg_in = 16'hF000; step();
    set_idle(); propagate = 1'b1; step();
    set_idle();
    check("tp1_valid", 32'(if0.fetch_valid), 32'd1);
    check("tp1_seg",   32'(if0.fetch_seg), 32'hF000);
    check("tp1_ofs",   32'(if1.fetch_ofs), 32'h1234);
    step();
    check("tp1_drained", 32'(if0.fetch_valid), 32'd0);

    // Two offset writes: first-wins vs last-wins, segment from cur_seg.
    ofs_update = 1'b1; ofs_in = 16'h0010; step();
    ofs_in = 16'h0020; step();
    set_idle(); propagate = 1'b1; step();
    check("mode_ofs_lw0", 32'(if0.fetch_ofs), 32'h0010);
    check("mode_seg_lw0", 32'(if0.fetch_seg), 32'h0700);
    check("mode_ofs_lw1", 32'(if1.fetch_ofs), 32'h0020);

    // Slot full, prefetcher stalled, new commit requested.
    fetch_ready = 1'b0; propagate = 1'b1; ofs_update = 1'b1; ofs_in = 16'h0100;
    #1;
    check("stall_asserted", 32'(stall0), 32'd1);
    step();
    check("stall_held_ofs", 32'(if0.fetch_ofs), 32'h0010);
    fetch_ready = 1'b1;
    #1;
    check("stall_released", 32'(stall0), 32'd0);
    step();
    set_idle();
    check("b2b_valid", 32'(if0.fetch_valid), 32'd1);
    check("b2b_ofs",   32'(if1.fetch_ofs), 32'h0100);
    step();

    // Abort beats propagate; the dropped segment write is not resurrected.
    seg_update = 1'b1; seg_in = 16'h1000; step();
    set_idle(); abort = 1'b1; propagate = 1'b1; step();
    check("abort_no_valid", 32'(if0.fetch_valid), 32'd0);
    set_idle(); propagate = 1'b1;
    #1;
    check("empty_prop_stall", 32'(stall0), 32'd0);
    step();
    set_idle();
    check("empty_prop_valid", 32'(if1.fetch_valid), 32'd0);

    // Asynchronous reset with a pair waiting on a stalled prefetcher.
    ofs_update = 1'b1; ofs_in = 16'h2222; propagate = 1'b1; fetch_ready = 1'b0; step();
    set_idle();
    check("pre_rst_full", 32'(if0.fetch_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(if0.fetch_valid), 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_seg", 32'(if0.fetch_seg), 32'd0);
    check("post_rst_ofs", 32'(if1.fetch_ofs), 32'd0);
    check("post_rst_pend", 32'({u_dut0.seg_pend, u_dut0.ofs_pend}), 32'd0);
    fetch_ready = 1'b1;
    step();

    // Random phase; update/propagate inputs are held while a stall is pending.
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall_prev) begin
        seg_update = ($urandom_range(3) == 0);
        ofs_update = ($urandom_range(3) == 0);
        seg_in     = 16'($urandom);
        ofs_in     = 16'($urandom);
        cur_seg    = 16'($urandom);
        cur_ofs    = 16'($urandom);
        propagate  = ($urandom_range(2) == 0);
        abort      = ($urandom_range(15) == 0);
      end
      fetch_ready = ($urandom_range(3) != 0);
      step();
    end

    set_idle();
    fetch_ready = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
